// File: rtl/controlador_interrupciones_pkg.sv
// Shared definitions for the interrupt controller and the PC / subroutine-stack
// modules that consume its entry pulse and vector.
package controlador_interrupciones_pkg;

  // Program counter width and IRQ0 vector address shared with the PC datapath.
  localparam int PC_W_DEF = 10;
  localparam logic [PC_W_DEF-1:0] VECTOR_BASE_DEF = 10'h3F0;

  // Width of the in-service line index (up to 8 lines).
  localparam int ID_W = 3;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ENTRY   = 2'b01,
    SERVICE = 2'b10
  } estado_e;

endpackage

// File: rtl/controlador_interrupciones_arbitro_prioridad.sv
// Fixed-priority encoder: the lowest-numbered active request wins.
module arbitro_prioridad
  import controlador_interrupciones_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the highest index down so the lowest active index is written last.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch to hold the old value.
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/controlador_interrupciones.sv
// Vectored interrupt controller: latches request edges, arbitrates among the
// enabled ones and sequences a one-cycle call-like entry at an instruction
// boundary, then holds in-service until the handler returns.
module controlador_interrupciones
  import controlador_interrupciones_pkg::*;
#(
  parameter int                NUM_IRQ     = 4,
  parameter int                PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0]   VECTOR_BASE = VECTOR_BASE_DEF,
  parameter int                VEC_STRIDE  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               gie_we,
  input  logic               gie_data,
  input  logic               boundary,
  input  logic               reti,
  input  logic               pila_llena,
  output logic               int_entry,
  output logic [PC_W-1:0]    vector,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  estado_e              state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_prev_q;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic                 gie_q, gie_d;
  logic [ID_W-1:0]      int_id_q, int_id_d;
  logic                 int_entry_q, int_entry_d;
  logic                 in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]   edge_w;
  logic [NUM_IRQ-1:0]   clr_w;
  logic                 arb_valid;
  logic [ID_W-1:0]      arb_id;

  // Winner among pending lines that are currently enabled.
  arbitro_prioridad #(.N(NUM_IRQ)) u_arbitro (
    .req   (pending_q & mask_q),
    .valid (arb_valid),
    .id    (arb_id)
  );

  // Next-state logic: edge capture, enable registers and entry sequencing.
  always_comb begin
    edge_w   = irq & ~irq_prev_q;
    mask_d   = mask_we ? mask_data : mask_q;
    gie_d    = gie_we ? gie_data : gie_q;
    state_d  = state_q;
    int_id_d = int_id_q;
    clr_w    = '0;

    case (state_q)
      IDLE: begin
        // A full stack blocks entry entirely; the request simply stays pending.
        if (gie_q && arb_valid && boundary && !pila_llena) begin
          int_id_d = arb_id;
          state_d  = ENTRY;
        end
      end
      ENTRY: begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          clr_w[i] = (int_id_q == ID_W'(i));
        end
        state_d = SERVICE;
      end
      SERVICE: begin
        if (reti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the line being acknowledged wins over the clear.
    pending_d    = (pending_q & ~clr_w) | edge_w;
    int_entry_d  = (state_d == ENTRY);
    in_service_d = (state_d == SERVICE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      int_id_q     <= '0;
      int_entry_q  <= 1'b0;
      in_service_q <= 1'b0;
      // Tracking the line during reset keeps a level held high across reset
      // from looking like a new rising edge afterwards.
      irq_prev_q   <= irq;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      int_id_q     <= int_id_d;
      int_entry_q  <= int_entry_d;
      in_service_q <= in_service_d;
      irq_prev_q   <= irq;
    end
  end

  // Vector follows the registered line index, wrapping within the PC space.
  always_comb begin
    vector = VECTOR_BASE + (PC_W'(int_id_q) * PC_W'(VEC_STRIDE));
  end

  assign int_entry  = int_entry_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Self-checking bench for the interrupt controller: a vector table driven
// through a scoreboard queue, then hand sequences for multi-cycle corners.
module tb_controlador_interrupciones;

  localparam int NUM_IRQ = 4;
  localparam int PC_W    = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_IRQ-1:0] irq;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_data;
  logic               gie_we;
  logic               gie_data;
  logic               boundary;
  logic               reti;
  logic               pila_llena;
  logic               int_entry;
  logic [PC_W-1:0]    vector;
  logic [2:0]         int_id;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  controlador_interrupciones #(
    .NUM_IRQ     (NUM_IRQ),
    .PC_W        (PC_W),
    .VECTOR_BASE (10'h3F0),
    .VEC_STRIDE  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_data  (mask_data),
    .gie_we     (gie_we),
    .gie_data   (gie_data),
    .boundary   (boundary),
    .reti       (reti),
    .pila_llena (pila_llena),
    .int_entry  (int_entry),
    .vector     (vector),
    .int_id     (int_id),
    .in_service (in_service),
    .pending    (pending)
  );

  typedef struct {
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_data;
    logic       gie_we;
    logic       gie_data;
    logic       boundary;
    logic       reti;
    logic       pila;
    logic       e_entry;
    logic [9:0] e_vector;
    logic [2:0] e_id;
    logic       e_ins;
    logic [3:0] e_pend;
  } vec_t;

  typedef struct {
    logic       entry;
    logic [9:0] vector;
    logic [2:0] id;
    logic       ins;
    logic [3:0] pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic vec_t mk(input logic [3:0] i_irq, input logic i_mwe, input logic [3:0] i_md,
                              input logic i_gwe, input logic i_gd, input logic i_bnd,
                              input logic i_reti, input logic i_pila, input logic x_entry,
                              input logic [9:0] x_vec, input logic [2:0] x_id,
                              input logic x_ins, input logic [3:0] x_pend);
    vec_t v;
    v.irq = i_irq; v.mask_we = i_mwe; v.mask_data = i_md; v.gie_we = i_gwe;
    v.gie_data = i_gd; v.boundary = i_bnd; v.reti = i_reti; v.pila = i_pila;
    v.e_entry = x_entry; v.e_vector = x_vec; v.e_id = x_id; v.e_ins = x_ins; v.e_pend = x_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;

    reset = 1'b0; irq = '0; mask_we = 1'b0; mask_data = '0; gie_we = 1'b0;
    gie_data = 1'b0; boundary = 1'b0; reti = 1'b0; pila_llena = 1'b0;

    //          irq    mwe md       gwe gd bnd reti pila | entry vec     id ins pend
    tbl.push_back(mk(4'b0000, 1, 4'b1111, 1, 1, 1, 0, 0,   0, 10'h3F0, 0, 0, 4'b0000)); // 0 enable all
    tbl.push_back(mk(4'b0100, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3F0, 0, 0, 4'b0100)); // 1 irq2 edge
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   1, 10'h3F8, 2, 0, 4'b0100)); // 2 entry irq2
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3F8, 2, 1, 4'b0000)); // 3 service
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 1, 0,   0, 10'h3F8, 2, 0, 4'b0000)); // 4 reti
    tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3F8, 2, 0, 4'b1010)); // 5 irq3+irq1
    tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 0, 1, 0, 0,   1, 10'h3F4, 1, 0, 4'b1010)); // 6 irq1 wins
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3F4, 1, 1, 4'b1000)); // 7 service
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3F4, 1, 1, 4'b1000)); // 8 no nesting
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 1, 0,   0, 10'h3F4, 1, 0, 4'b1000)); // 9 reti
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   1, 10'h3FC, 3, 0, 4'b1000)); // 10 irq3 entry
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3FC, 3, 1, 4'b0000)); // 11 service
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 1, 0,   0, 10'h3FC, 3, 0, 4'b0000)); // 12 reti
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3FC, 3, 0, 4'b0000)); // 13 mask all off
    tbl.push_back(mk(4'b0010, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3FC, 3, 0, 4'b0010)); // 14 irq1 edge
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3FC, 3, 0, 4'b0010)); // 15 masked
    tbl.push_back(mk(4'b0000, 1, 4'b0010, 0, 0, 1, 0, 0,   0, 10'h3FC, 3, 0, 4'b0010)); // 16 unmask strobe
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   1, 10'h3F4, 1, 0, 4'b0010)); // 17 entry irq1
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0,   0, 10'h3F4, 1, 1, 4'b0000)); // 18 service
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 1, 0,   0, 10'h3F4, 1, 0, 4'b0000)); // 19 reti
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 1, 0,   0, 10'h3F4, 1, 0, 4'b0000)); // 20 reti in IDLE

    // Reset state.
    tick(); tick();
    check("rst int_entry", 32'(int_entry), 32'd0);
    check("rst in_service", 32'(in_service), 32'd0);
    check("rst int_id", 32'(int_id), 32'd0);
    check("rst vector", 32'(vector), 32'h3F0);
    check("rst pending", 32'(pending), 32'd0);
    reset = 1'b1;

    // Table vectors through the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      irq = tbl[i].irq; mask_we = tbl[i].mask_we; mask_data = tbl[i].mask_data;
      gie_we = tbl[i].gie_we; gie_data = tbl[i].gie_data; boundary = tbl[i].boundary;
      reti = tbl[i].reti; pila_llena = tbl[i].pila;
      sb_q.push_back('{entry: tbl[i].e_entry, vector: tbl[i].e_vector, id: tbl[i].e_id,
                       ins: tbl[i].e_ins, pend: tbl[i].e_pend});
      tick();
      e = sb_q.pop_front();
      check($sformatf("row%0d int_entry", i), 32'(int_entry), 32'(e.entry));
      check($sformatf("row%0d vector", i), 32'(vector), 32'(e.vector));
      check($sformatf("row%0d int_id", i), 32'(int_id), 32'(e.id));
      check($sformatf("row%0d in_service", i), 32'(in_service), 32'(e.ins));
      check($sformatf("row%0d pending", i), 32'(pending), 32'(e.pend));
    end
    mask_we = 1'b0; gie_we = 1'b0; reti = 1'b0;

    // Stack full holds a pending request without entry.
    mask_we = 1'b1; mask_data = 4'b1111; tick(); mask_we = 1'b0;
    irq = 4'b0001; tick();
    check("pila edge pending", 32'(pending[0]), 32'd1);
    irq = 4'b0000; pila_llena = 1'b1; boundary = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("pila%0d int_entry", k), 32'(int_entry), 32'd0);
      check($sformatf("pila%0d pending0", k), 32'(pending[0]), 32'd1);
    end
    pila_llena = 1'b0; boundary = 1'b0; tick();
    check("no boundary int_entry", 32'(int_entry), 32'd0);
    boundary = 1'b1; tick();
    check("pila release int_entry", 32'(int_entry), 32'd1);
    check("pila release int_id", 32'(int_id), 32'd0);
    check("pila release vector", 32'(vector), 32'h3F0);
    tick();
    check("irq0 service int_entry", 32'(int_entry), 32'd0);
    check("irq0 service in_service", 32'(in_service), 32'd1);
    check("irq0 service pending0", 32'(pending[0]), 32'd0);

    // Same line during service stays pending; re-entry one cycle after reti.
    irq = 4'b0001; tick();
    check("nest pending0", 32'(pending[0]), 32'd1);
    check("nest int_entry", 32'(int_entry), 32'd0);
    check("nest in_service", 32'(in_service), 32'd1);
    irq = 4'b0000; tick();
    check("nest hold int_entry", 32'(int_entry), 32'd0);
    check("nest hold in_service", 32'(in_service), 32'd1);
    reti = 1'b1; tick(); reti = 1'b0;
    check("nest reti in_service", 32'(in_service), 32'd0);
    check("nest reti int_entry", 32'(int_entry), 32'd0);
    tick();
    check("reentry int_entry", 32'(int_entry), 32'd1);
    check("reentry int_id", 32'(int_id), 32'd0);
    tick();
    check("reentry in_service", 32'(in_service), 32'd1);
    check("reentry pending0", 32'(pending[0]), 32'd0);

    // Edge on the acknowledged line during ENTRY keeps it pending.
    reti = 1'b1; tick(); reti = 1'b0; boundary = 1'b0;
    irq = 4'b0001; tick();
    check("setwin pre pending0", 32'(pending[0]), 32'd1);
    irq = 4'b0000; boundary = 1'b1; tick();
    check("setwin int_entry", 32'(int_entry), 32'd1);
    irq = 4'b0001; tick();
    check("setwin in_service", 32'(in_service), 32'd1);
    check("setwin pending0", 32'(pending[0]), 32'd1);

    // Reset during service discards everything; held lines do not trigger.
    irq = 4'b1111; reset = 1'b0; tick();
    check("midrst in_service", 32'(in_service), 32'd0);
    check("midrst int_entry", 32'(int_entry), 32'd0);
    check("midrst pending", 32'(pending), 32'd0);
    check("midrst int_id", 32'(int_id), 32'd0);
    check("midrst vector", 32'(vector), 32'h3F0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("postrst%0d int_entry", k), 32'(int_entry), 32'd0);
      check($sformatf("postrst%0d in_service", k), 32'(in_service), 32'd0);
    end
    gie_we = 1'b1; gie_data = 1'b1; tick(); gie_we = 1'b0;
    tick(); tick();
    check("postrst mask cleared int_entry", 32'(int_entry), 32'd0);
    check("postrst mask cleared in_service", 32'(in_service), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
